multicycle_ctrl: RTL

Multi-cycle MIPS control unit that sequences the shared 32-bit ALU, register file, IR/PC and unified memory port over several cycles per instruction. It decodes op/funct into a state sequence, drives the ALU's 3-bit control code and consumes the ALU zero flag for branches. It also waits on a memory-ready handshake and includes a watchdog counter.

---
 rtl/mcpu_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 24 ++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, functs, ALU codes
// and the FSM state encoding.
package mcpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEM_ADR = 4'd2;
    localparam logic [3:0] ST_MEM_RD  = 4'd3;
    localparam logic [3:0] ST_MEM_WB  = 4'd4;
    localparam logic [3:0] ST_MEM_WR  = 4'd5;
    localparam logic [3:0] ST_EXEC    = 4'd6;
    localparam logic [3:0] ST_ALU_WB  = 4'd7;
    localparam logic [3:0] ST_BRANCH  = 4'd8;
    localparam logic [3:0] ST_JUMP    = 4'd9;
    localparam logic [3:0] ST_ADDI_EX = 4'd10;
    localparam logic [3:0] ST_ADDI_WB = 4'd11;

    typedef enum logic [3:0] {
        StFetch  = ST_FETCH,
        StDecode = ST_DECODE,
        StMemAdr = ST_MEM_ADR,
        StMemRd  = ST_MEM_RD,
        StMemWb  = ST_MEM_WB,
        StMemWr  = ST_MEM_WR,
        StExec   = ST_EXEC,
        StAluWb  = ST_ALU_WB,
        StBranch = ST_BRANCH,
        StJump   = ST_JUMP,
        StAddiEx = ST_ADDI_EX,
        StAddiWb = ST_ADDI_WB
    } state_e;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decode to the 3-bit ALU control code; unknown functs fall back to add
// and raise funct_illegal.
module alu_decoder
    import mcpu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared ALU and
// unified memory port, with a mem_ready handshake and an optional wait watchdog.
module multicycle_ctrl
    import mcpu_pkg::*;
#(
    parameter int unsigned SUPPORT_BNE = 1,
    parameter int unsigned TIMEOUT     = 0,
    parameter int unsigned TMO_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_e            state_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              funct_bad_q;

    logic [2:0]        dec_alu;
    logic              dec_bad;
    logic              bne_ok;
    logic              op_known;
    logic              wait_st;
    logic              expired;

    alu_decoder u_alu_decoder (
        .funct         (funct),
        .alu_control   (dec_alu),
        .funct_illegal (dec_bad)
    );

    assign bne_ok   = (SUPPORT_BNE != 0) && (op == OP_BNE);
    assign op_known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
                      (op == OP_J) || (op == OP_ADDI) || bne_ok;
    assign wait_st  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // Expiry needs a full TIMEOUT wait cycles already counted; a late mem_ready still wins.
    assign expired  = (TIMEOUT != 0) && wait_st && !mem_ready && (tmo_q == TMO_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            tmo_q       <= '0;
            funct_bad_q <= 1'b0;
        end else begin
            if ((TIMEOUT != 0) && wait_st && !mem_ready && !expired) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end else begin
                tmo_q <= '0;
            end
            if (state_q == StExec) begin
                funct_bad_q <= dec_bad;
            end
            case (state_q)
                StFetch: begin
                    if (mem_ready) state_q <= StDecode;
                end
                StDecode: begin
                    if (op == OP_RTYPE)                    state_q <= StExec;
                    else if ((op == OP_LW) || (op == OP_SW)) state_q <= StMemAdr;
                    else if ((op == OP_BEQ) || bne_ok)     state_q <= StBranch;
                    else if (op == OP_J)                   state_q <= StJump;
                    else if (op == OP_ADDI)                state_q <= StAddiEx;
                    else                                   state_q <= StFetch;
                end
                StMemAdr: state_q <= (op == OP_LW) ? StMemRd : StMemWr;
                StMemRd: begin
                    if (mem_ready)    state_q <= StMemWb;
                    else if (expired) state_q <= StFetch;
                end
                StMemWr: begin
                    if (mem_ready || expired) state_q <= StFetch;
                end
                StExec:   state_q <= StAluWb;
                StAddiEx: state_q <= StAddiWb;
                default:  state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_source   = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        state       = ST_FETCH;
        if (rst_n) begin
            state       = state_q;
            mem_timeout = expired;
            case (state_q)
                StFetch: begin
                    mem_read    = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    ir_write    = mem_ready;
                    pc_en       = mem_ready;
                end
                StDecode: begin
                    alu_src_b   = 2'b11;
                    alu_control = ALU_ADD;
                    illegal_op  = !op_known;
                end
                StMemAdr, StAddiEx: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                StExec: begin
                    alu_src_a   = 1'b1;
                    alu_control = dec_alu;
                    illegal_op  = dec_bad;
                end
                StAluWb: begin
                    reg_write = !funct_bad_q;
                    reg_dst   = 1'b1;
                end
                StBranch: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_SUB;
                    pc_source   = 2'b01;
                    pc_en       = bne_ok ? !zero : zero;
                end
                StJump: begin
                    pc_source = 2'b10;
                    pc_en     = 1'b1;
                end
                StAddiWb: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
